// File: rtl/alu_op_sequencer_if.sv
// Command/response handshake bundle between a requester and the ALU sequencer.
// The master side issues commands and consumes responses; the slave side is the sequencer.
interface alu_op_sequencer_if #(
  parameter int W = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_carry;
  logic [1:0]   rsp_op;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_op
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_op
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Transaction front-end for a 4-bit combinational ALU: latches one command onto the ALU
// inputs, waits a settle window, captures the result and presents it as a response.
module alu_op_sequencer #(
   parameter int W          = 4,
   parameter int SETTLE_CYC = 1,
   parameter int CNT_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_op_sequencer_if.slave    bus,
   output logic                 alu_s0_o,
   output logic                 alu_s1_o,
   output logic [W-1:0]         alu_a_o,
   output logic [W-1:0]         alu_b_o,
   input  logic [W-1:0]         alu_sum_i,
   input  logic                 alu_carry_i,
   input  logic [2:0]           alu_y_i,
   input  logic [W-1:0]         alu_y_and_i,
   output logic [CNT_W-1:0]     ops_done_o
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_COMP = 2'b10;

   logic [1:0]       state_q,     state_d;
   logic [3:0]       cnt_q,       cnt_d;
   logic [1:0]       op_q,        op_d;
   logic [W-1:0]     a_q,         a_d;
   logic [W-1:0]     b_q,         b_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [W-1:0]     rsp_data_q,  rsp_data_d;
   logic             rsp_carry_q, rsp_carry_d;
   logic [1:0]       rsp_op_q,    rsp_op_d;
   logic [CNT_W-1:0] ops_done_q,  ops_done_d;

   function automatic logic [W-1:0] sel_data(input logic [1:0]   op,
                                             input logic [W-1:0] sum,
                                             input logic [2:0]   y,
                                             input logic [W-1:0] y_and);
      case (op)
         OP_ADD, OP_SUB: sel_data = sum;
         OP_COMP:        sel_data = {{(W-3){1'b0}}, y};
         default:        sel_data = y_and;
      endcase
   endfunction

   function automatic logic sel_carry(input logic [1:0] op, input logic carry);
      sel_carry = ((op == OP_ADD) || (op == OP_SUB)) ? carry : 1'b0;
   endfunction

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_carry_d = rsp_carry_q;
      rsp_op_d    = rsp_op_q;
      ops_done_d  = ops_done_q;
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               op_d    = bus.cmd_op;
               a_d     = bus.cmd_a;
               b_d     = bus.cmd_b;
               cnt_d   = 4'd0;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            cnt_d = cnt_q + 4'd1;
            // The ALU is purely combinational; its outputs are sampled only at the window's end.
            if (cnt_q == SETTLE_LAST) begin
               rsp_data_d  = sel_data(op_q, alu_sum_i, alu_y_i, alu_y_and_i);
               rsp_carry_d = sel_carry(op_q, alu_carry_i);
               rsp_op_d    = op_q;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               ops_done_d  = ops_done_q + 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         op_q        <= 2'b00;
         a_q         <= '0;
         b_q         <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_carry_q <= 1'b0;
         rsp_op_q    <= 2'b00;
         ops_done_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_carry_q <= rsp_carry_d;
         rsp_op_q    <= rsp_op_d;
         ops_done_q  <= ops_done_d;
      end
   end

   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_carry = rsp_carry_q;
   assign bus.rsp_op    = rsp_op_q;

   assign alu_s0_o   = op_q[0];
   assign alu_s1_o   = op_q[1];
   assign alu_a_o    = a_q;
   assign alu_b_o    = b_q;
   assign ops_done_o = ops_done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance with a 1-cycle settle window and one
// with a 3-cycle window, each wired to a small behavioural model of the 4-bit ALU.
module tb_alu_op_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   alu_op_sequencer_if #(.W(4)) if1 ();
   alu_op_sequencer_if #(.W(4)) if3 ();

   logic       s0_1, s1_1, carry_1;
   logic [3:0] a_1, b_1, sum_1, yand_1;
   logic [2:0] y_1;
   logic [7:0] done_1;
   logic [4:0] add_1;

   logic       s0_3, s1_3, carry_3;
   logic [3:0] a_3, b_3, sum_3, yand_3;
   logic [2:0] y_3;
   logic [7:0] done_3;
   logic [4:0] add_3;

   // Behavioural ALU: SUB is a + ~b + 1, so carry-out set means no borrow.
   assign add_1   = s0_1 ? ({1'b0, a_1} + {1'b0, ~b_1} + 5'd1) : ({1'b0, a_1} + {1'b0, b_1});
   assign sum_1   = add_1[3:0];
   assign carry_1 = add_1[4];
   assign y_1     = {a_1 == b_1, a_1 > b_1, a_1 < b_1};
   assign yand_1  = a_1 & b_1;

   assign add_3   = s0_3 ? ({1'b0, a_3} + {1'b0, ~b_3} + 5'd1) : ({1'b0, a_3} + {1'b0, b_3});
   assign sum_3   = add_3[3:0];
   assign carry_3 = add_3[4];
   assign y_3     = {a_3 == b_3, a_3 > b_3, a_3 < b_3};
   assign yand_3  = a_3 & b_3;

   alu_op_sequencer #(.W(4), .SETTLE_CYC(1), .CNT_W(8)) dut1 (
      .clk(clk), .rst(rst), .bus(if1),
      .alu_s0_o(s0_1), .alu_s1_o(s1_1), .alu_a_o(a_1), .alu_b_o(b_1),
      .alu_sum_i(sum_1), .alu_carry_i(carry_1), .alu_y_i(y_1), .alu_y_and_i(yand_1),
      .ops_done_o(done_1)
   );

   alu_op_sequencer #(.W(4), .SETTLE_CYC(3), .CNT_W(8)) dut3 (
      .clk(clk), .rst(rst), .bus(if3),
      .alu_s0_o(s0_3), .alu_s1_o(s1_3), .alu_a_o(a_3), .alu_b_o(b_3),
      .alu_sum_i(sum_3), .alu_carry_i(carry_3), .alu_y_i(y_3), .alu_y_and_i(yand_3),
      .ops_done_o(done_3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op1(input string tag, input logic [1:0] op, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] exp_d, input logic exp_c);
      if1.cmd_valid = 1'b1; if1.cmd_op = op; if1.cmd_a = a; if1.cmd_b = b;
      tick();
      if1.cmd_valid = 1'b0;
      chk({tag, "_settle_valid"}, 32'(if1.rsp_valid), 32'd0);
      tick();
      chk({tag, "_valid"}, 32'(if1.rsp_valid), 32'd1);
      chk({tag, "_data"},  32'(if1.rsp_data),  32'(exp_d));
      chk({tag, "_carry"}, 32'(if1.rsp_carry), 32'(exp_c));
      chk({tag, "_op"},    32'(if1.rsp_op),    32'(op));
      if1.rsp_ready = 1'b1;
      tick();
      if1.rsp_ready = 1'b0;
      chk({tag, "_drop"},  32'(if1.rsp_valid), 32'd0);
   endtask

   task automatic op3_quiet(input logic [3:0] a);
      if3.cmd_valid = 1'b1; if3.cmd_op = 2'b11; if3.cmd_a = a; if3.cmd_b = 4'hf;
      tick();
      if3.cmd_valid = 1'b0;
      tick(); tick(); tick();
      if3.rsp_ready = 1'b1;
      tick();
      if3.rsp_ready = 1'b0;
   endtask

   initial begin
      if1.cmd_valid = 1'b0; if1.cmd_op = 2'b00; if1.cmd_a = 4'h0; if1.cmd_b = 4'h0; if1.rsp_ready = 1'b0;
      if3.cmd_valid = 1'b0; if3.cmd_op = 2'b00; if3.cmd_a = 4'h0; if3.cmd_b = 4'h0; if3.rsp_ready = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_cmd_ready", 32'(if1.cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(if1.rsp_valid), 32'd0);
      chk("rst_rsp_data",  32'(if1.rsp_data),  32'd0);
      chk("rst_alu_a",     32'(a_1),           32'd0);
      chk("rst_ops_done",  32'(done_1),        32'd0);
      rst = 1'b0;
      tick();

      // T1: ADD 1+1 with explicit latency checks
      if1.cmd_valid = 1'b1; if1.cmd_op = 2'b00; if1.cmd_a = 4'h1; if1.cmd_b = 4'h1;
      tick();
      if1.cmd_valid = 1'b0;
      chk("t1_cmd_ready", 32'(if1.cmd_ready), 32'd0);
      chk("t1_alu_ab",    32'({a_1, b_1}),    32'h11);
      chk("t1_valid0",    32'(if1.rsp_valid), 32'd0);
      tick();
      chk("t1_valid",     32'(if1.rsp_valid), 32'd1);
      chk("t1_data",      32'(if1.rsp_data),  32'h2);
      chk("t1_carry",     32'(if1.rsp_carry), 32'd0);
      chk("t1_op",        32'(if1.rsp_op),    32'd0);
      if1.rsp_ready = 1'b1;
      tick();
      if1.rsp_ready = 1'b0;
      chk("t1_drop",      32'(if1.rsp_valid), 32'd0);
      chk("t1_ready_back", 32'(if1.cmd_ready), 32'd1);
      chk("t1_ops_done",  32'(done_1),        32'd1);

      // T2/T3: arithmetic, compare and AND results
      op1("sub_f_d",  2'b01, 4'hf, 4'hd, 4'h2, 1'b1);
      op1("add_f_1",  2'b00, 4'hf, 4'h1, 4'h0, 1'b1);
      op1("sub_3_5",  2'b01, 4'h3, 4'h5, 4'he, 1'b0);
      op1("comp_lt",  2'b10, 4'h6, 4'h7, 4'h1, 1'b0);
      op1("comp_gt",  2'b10, 4'h8, 4'h3, 4'h2, 1'b0);
      op1("comp_eq",  2'b10, 4'h7, 4'h7, 4'h4, 1'b0);
      op1("and_7_6",  2'b11, 4'h7, 4'h6, 4'h6, 1'b0);
      chk("ops_done_8", 32'(done_1), 32'd8);

      // T4: response backpressure with a competing command
      if1.cmd_valid = 1'b1; if1.cmd_op = 2'b01; if1.cmd_a = 4'h5; if1.cmd_b = 4'h3;
      tick();
      if1.cmd_op = 2'b00; if1.cmd_a = 4'h3; if1.cmd_b = 4'h3;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid",     32'(if1.rsp_valid), 32'd1);
         chk("bp_data",      32'(if1.rsp_data),  32'h2);
         chk("bp_cmd_ready", 32'(if1.cmd_ready), 32'd0);
         chk("bp_alu_a",     32'(a_1),           32'h5);
         tick();
      end
      if1.rsp_ready = 1'b1;
      tick();
      if1.rsp_ready = 1'b0;
      chk("bp_drop",      32'(if1.rsp_valid), 32'd0);
      chk("bp_no_accept", 32'(a_1),           32'h5);
      tick();
      if1.cmd_valid = 1'b0;
      chk("bp_accept_a",  32'(a_1),           32'h3);
      chk("bp_busy",      32'(if1.cmd_ready), 32'd0);
      tick();
      chk("bp2_data",     32'(if1.rsp_data),  32'h6);
      chk("bp2_op",       32'(if1.rsp_op),    32'd0);
      if1.rsp_ready = 1'b1;
      tick();
      if1.rsp_ready = 1'b0;
      chk("bp_ops_done",  32'(done_1),        32'd10);

      // T6: reset while in SETTLE, then while in RESP
      if1.cmd_valid = 1'b1; if1.cmd_op = 2'b00; if1.cmd_a = 4'h2; if1.cmd_b = 4'h2;
      tick();
      if1.cmd_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rs_cmd_ready", 32'(if1.cmd_ready), 32'd1);
      chk("rs_alu_a",     32'(a_1),           32'd0);
      chk("rs_valid",     32'(if1.rsp_valid), 32'd0);
      chk("rs_ops_done",  32'(done_1),        32'd0);
      #2 rst = 1'b0;
      tick();
      if1.cmd_valid = 1'b1; if1.cmd_op = 2'b11; if1.cmd_a = 4'hc; if1.cmd_b = 4'ha;
      tick();
      if1.cmd_valid = 1'b0;
      tick();
      chk("rr_pre_data",  32'(if1.rsp_data),  32'h8);
      rst = 1'b1;
      #1;
      chk("rr_valid",     32'(if1.rsp_valid), 32'd0);
      chk("rr_data",      32'(if1.rsp_data),  32'd0);
      chk("rr_op",        32'(if1.rsp_op),    32'd0);
      chk("rr_cmd_ready", 32'(if1.cmd_ready), 32'd1);
      #2 rst = 1'b0;
      tick();
      op1("post_rst_and", 2'b11, 4'hf, 4'hf, 4'hf, 1'b0);
      chk("post_rst_done", 32'(done_1), 32'd1);

      // T5: 3-cycle settle window, then counter wrap
      if3.cmd_valid = 1'b1; if3.cmd_op = 2'b00; if3.cmd_a = 4'h9; if3.cmd_b = 4'h8;
      tick();
      if3.cmd_valid = 1'b0;
      if3.cmd_a = 4'h0;
      for (int i = 0; i < 2; i++) begin
         chk("s3_wait_valid", 32'(if3.rsp_valid), 32'd0);
         chk("s3_alu_ab",     32'({a_3, b_3}),    32'h98);
         tick();
      end
      chk("s3_alu_hold", 32'({a_3, b_3}),    32'h98);
      chk("s3_valid0",   32'(if3.rsp_valid), 32'd0);
      tick();
      chk("s3_valid",    32'(if3.rsp_valid), 32'd1);
      chk("s3_data",     32'(if3.rsp_data),  32'h1);
      chk("s3_carry",    32'(if3.rsp_carry), 32'd1);
      if3.rsp_ready = 1'b1;
      tick();
      if3.rsp_ready = 1'b0;
      chk("s3_done1",    32'(done_3),        32'd1);
      for (int i = 0; i < 254; i++) op3_quiet(4'(i));
      chk("s3_done255",  32'(done_3),        32'd255);
      op3_quiet(4'h5);
      chk("s3_wrap",     32'(done_3),        32'd0);
      chk("s3_last_data", 32'(if3.rsp_data), 32'h5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
